// File: rtl/pe_pkg.sv
// Constants shared by the request latch and the priority encoder it feeds.
package pe_pkg;

  function automatic int pe_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int PE_N_REQ = 3;
  localparam int PE_IDX_W = (pe_clog2(PE_N_REQ) < 1) ? 1 : pe_clog2(PE_N_REQ);

endpackage

// File: rtl/pe_sync2.sv
// Single-bit two-flop synchroniser for request lines from another clock domain.
// Latency: 2 clk edges. No backpressure.
module pe_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pe_request_latch.sv
// Edge-captures request lines into sticky pending bits for the priority encoder.
// Latency req_in rise -> pend_out: 3 edges with PE_REQ_SYNC_EN, else 1. No backpressure; lost edges flag overflow.
// PE_REQ_SYNC_EN: insert a 2-flop synchroniser on every req_in bit.
module pe_request_latch
  import pe_pkg::*;
#(
  parameter int N_REQ = PE_N_REQ,
  parameter int IDX_W = PE_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             ovf_clr,
  output logic [N_REQ-1:0] pend_out,
  output logic             pend_valid,
  output logic [N_REQ-1:0] overflow
);

  logic [N_REQ-1:0] cur;
  logic [N_REQ-1:0] prev;
  logic [N_REQ-1:0] det;
  logic [N_REQ-1:0] ack_hit;
  logic [N_REQ-1:0] pending;

`ifdef PE_REQ_SYNC_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_sync
    pe_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_in[g]),
      .q     (cur[g])
    );
  end
`else
  assign cur = req_in;
`endif

  assign det = cur & ~prev;

  // Out-of-range ack_idx decodes to no line, so it is silently ignored.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ack && (ack_idx == IDX_W'(i))) ack_hit[i] = 1'b1;
    end
  end

  // A new edge beats a same-cycle ack, and a new overflow beats ovf_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      prev     <= cur;
      pending  <= det | (pending & ~ack_hit);
      overflow <= (ovf_clr ? '0 : overflow) | (det & pending & ~ack_hit);
    end
  end

  assign pend_out   = pending & ~mask;
  assign pend_valid = |pend_out;

endmodule

// File: tb/tb_pe_request_latch.sv
// Directed scoreboard bench for pe_request_latch; works with or without PE_REQ_SYNC_EN.
module tb_pe_request_latch;

`ifdef PE_REQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_in;
  logic [2:0] mask;
  logic       ack;
  logic [1:0] ack_idx;
  logic       ovf_clr;
  logic [2:0] pend_out;
  logic       pend_valid;
  logic [2:0] overflow;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      tag;
    logic [2:0] pend;
    logic       vld;
    logic [2:0] ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pe_request_latch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .mask       (mask),
    .ack        (ack),
    .ack_idx    (ack_idx),
    .ovf_clr    (ovf_clr),
    .pend_out   (pend_out),
    .pend_valid (pend_valid),
    .overflow   (overflow)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] pend,
                            input logic vld, input logic [2:0] ovf);
    exp_t e;
    e.tag  = tag;
    e.pend = pend;
    e.vld  = vld;
    e.ovf  = ovf;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) n_pass++;
    else $error("FAIL scoreboard_empty: queue size %0d, required nonzero", sb.size());
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      assert (pend_out === e.pend) n_pass++;
      else $error("FAIL %s.pend_out: got %b, expected %b", e.tag, pend_out, e.pend);
      n_checks++;
      assert (pend_valid === e.vld) n_pass++;
      else $error("FAIL %s.pend_valid: got %b, expected %b", e.tag, pend_valid, e.vld);
      n_checks++;
      assert (overflow === e.ovf) n_pass++;
      else $error("FAIL %s.overflow: got %b, expected %b", e.tag, overflow, e.ovf);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req_in  = 3'b111;
    mask    = 3'b000;
    ack     = 1'b0;
    ack_idx = 2'd0;
    ovf_clr = 1'b0;

    // 1: reset with requests held high, then one capture after release
    expect_out("reset", 3'b000, 1'b0, 3'b000);
    step(2);
    check_out();
    rst_n = 1'b1;
    expect_out("release_early", 3'b000, 1'b0, 3'b000);
    step(LAT - 1);
    check_out();
    expect_out("release_held", 3'b111, 1'b1, 3'b000);
    step(1);
    check_out();
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ack_idx = 2'(i);
      step(1);
    end
    ack = 1'b0;
    expect_out("held_no_redet", 3'b000, 1'b0, 3'b000);
    check_out();
    req_in = 3'b000;
    step(LAT + 1);

    // 2: single one-cycle pulse, then ack
    req_in = 3'b010;
    step(1);
    req_in = 3'b000;
    expect_out("single_req", 3'b010, 1'b1, 3'b000);
    step(LAT - 1);
    check_out();
    ack = 1'b1; ack_idx = 2'd1;
    step(1);
    ack = 1'b0;
    expect_out("single_ack", 3'b000, 1'b0, 3'b000);
    check_out();
    step(LAT + 1);

    // 3: set beats same-cycle ack clear, no overflow
    req_in = 3'b001;
    step(1);
    req_in = 3'b000;
    expect_out("pend0", 3'b001, 1'b1, 3'b000);
    step(LAT - 1);
    check_out();
    step(2);
    req_in = 3'b001;
    step(LAT - 1);
    ack = 1'b1; ack_idx = 2'd0;
    step(1);
    ack = 1'b0;
    req_in = 3'b000;
    expect_out("set_vs_clear", 3'b001, 1'b1, 3'b000);
    check_out();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    expect_out("clear0", 3'b000, 1'b0, 3'b000);
    check_out();
    step(LAT + 1);

    // 4: overflow from two pulses 5 clk apart, then ovf_clr
    req_in = 3'b100;
    step(1);
    req_in = 3'b000;
    step(4);
    req_in = 3'b100;
    step(1);
    req_in = 3'b000;
    expect_out("overflow", 3'b100, 1'b1, 3'b100);
    step(LAT);
    check_out();
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    expect_out("ovf_clr", 3'b100, 1'b1, 3'b000);
    check_out();
    step(LAT + 1);
    req_in = 3'b100;
    step(LAT - 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    req_in = 3'b000;
    expect_out("ovf_set_beats_clr", 3'b100, 1'b1, 3'b100);
    check_out();
    ovf_clr = 1'b1; ack = 1'b1; ack_idx = 2'd2;
    step(1);
    ovf_clr = 1'b0; ack = 1'b0;
    expect_out("ovf_clr_ack2", 3'b000, 1'b0, 3'b000);
    check_out();
    step(LAT + 1);

    // 5: mask and out-of-range ack
    req_in = 3'b011;
    step(1);
    req_in = 3'b000;
    step(LAT - 1);
    mask = 3'b001;
    #1;
    expect_out("mask001", 3'b010, 1'b1, 3'b000);
    check_out();
    ack = 1'b1; ack_idx = 2'd3;
    step(1);
    ack = 1'b0;
    expect_out("bad_ack", 3'b010, 1'b1, 3'b000);
    check_out();
    mask = 3'b011;
    #1;
    expect_out("mask011", 3'b000, 1'b0, 3'b000);
    check_out();
    mask = 3'b000;
    #1;
    expect_out("unmask", 3'b011, 1'b1, 3'b000);
    check_out();

    // 6: async reset between edges
    ack = 1'b1; ack_idx = 2'd1;
    step(1);
    ack = 1'b0;
    req_in = 3'b101;
    step(1);
    req_in = 3'b000;
    expect_out("pre_async", 3'b101, 1'b1, 3'b001);
    step(LAT);
    check_out();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 3'b000, 1'b0, 3'b000);
    check_out();

    n_checks++;
    assert (sb.size() == 0) n_pass++;
    else $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
